// File: rtl/de_hazard_ctrl_pkg.sv
// Shared definitions for the decode/execute hazard controller: register index
// width, FSM state encoding and scoreboard depth.
package de_hazard_ctrl_pkg;

    localparam int REGBITS_DEF = 4;
    localparam int SB_SLOTS    = 3;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        RUN   = ST_RUN,
        STALL = ST_STALL,
        FLUSH = ST_FLUSH
    } state_e;

endpackage

// File: rtl/de_hazard_ctrl_scoreboard.sv
// Three-slot shift register of in-flight register writes (E, M, W) and the
// source-match logic that detects RAW hazards against any valid slot.
module hazard_scoreboard
    import de_hazard_ctrl_pkg::*;
#(
    parameter int REGBITS = REGBITS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_i,
    input  logic [REGBITS-1:0] dest_i,
    input  logic [REGBITS-1:0] src1_i,
    input  logic [REGBITS-1:0] src2_i,
    output logic               hit1_o,
    output logic               hit2_o
);

    typedef struct packed {
        logic               valid;
        logic [REGBITS-1:0] dest;
    } slot_t;

    slot_t sb_q [SB_SLOTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SB_SLOTS; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q[0] <= '{valid: issue_i, dest: dest_i};
            for (int k = 1; k < SB_SLOTS; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    // Register file writes at the end of W, so the W slot still blocks readers.
    always_comb begin
        hit1_o = 1'b0;
        hit2_o = 1'b0;
        for (int k = 0; k < SB_SLOTS; k++) begin
            if (sb_q[k].valid && (sb_q[k].dest == src1_i)) hit1_o = 1'b1;
            if (sb_q[k].valid && (sb_q[k].dest == src2_i)) hit2_o = 1'b1;
        end
    end

endmodule

// File: rtl/de_hazard_ctrl.sv
// Producer-side controller for the F/D and D/E pipeline buffers: stalls decode on
// RAW hazards, squashes F/D on mispredicts and counts stall/flush cycles.
module de_hazard_ctrl
    import de_hazard_ctrl_pkg::*;
#(
    parameter int REGBITS      = REGBITS_DEF,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNTBITS      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_D,
    input  logic [REGBITS-1:0] src1Index_D,
    input  logic [REGBITS-1:0] src2Index_D,
    input  logic               useSrc1_D,
    input  logic               useSrc2_D,
    input  logic [REGBITS-1:0] destIndex_D,
    input  logic               regWrtEn_D,
    input  logic               mispredict_E,
    output logic               pcWrtEn,
    output logic               fdWrtEn,
    output logic               fdNoop,
    output logic               deWrtEn,
    output logic               deNoop,
    output logic [CNTBITS-1:0] stallCnt,
    output logic [CNTBITS-1:0] flushCnt,
    output logic [1:0]         dbgState
);

    localparam int FLBITS = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    state_e             state_q, state_d;
    logic [FLBITS-1:0]  flushLeft_q, flushLeft_d;
    logic [CNTBITS-1:0] stallCnt_q, stallCnt_d;
    logic [CNTBITS-1:0] flushCnt_q, flushCnt_d;

    logic hit1, hit2, hazard, squash, issue;

    assign squash = mispredict_E | (state_q == FLUSH);
    assign hazard = valid_D & ((useSrc1_D & hit1) | (useSrc2_D & hit2));
    assign issue  = valid_D & ~hazard & ~squash & ~reset;

    hazard_scoreboard #(
        .REGBITS (REGBITS)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .issue_i (issue & regWrtEn_D),
        .dest_i  (destIndex_D),
        .src1_i  (src1Index_D),
        .src2_i  (src2Index_D),
        .hit1_o  (hit1),
        .hit2_o  (hit2)
    );

    always_comb begin
        state_d     = RUN;
        flushLeft_d = flushLeft_q;
        pcWrtEn     = 1'b1;
        fdWrtEn     = 1'b1;
        fdNoop      = 1'b0;
        deWrtEn     = 1'b1;
        deNoop      = ~valid_D;
        if (reset) begin
            // Both buffers keep loading bubbles while the PC is held.
            pcWrtEn     = 1'b0;
            fdNoop      = 1'b1;
            deNoop      = 1'b1;
            flushLeft_d = '0;
        end else if (mispredict_E) begin
            fdNoop = 1'b1;
            deNoop = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d     = FLUSH;
                flushLeft_d = FLBITS'(FLUSH_CYCLES - 1);
            end else begin
                flushLeft_d = '0;
            end
        end else if (state_q == FLUSH) begin
            fdNoop      = 1'b1;
            deNoop      = 1'b1;
            flushLeft_d = flushLeft_q - FLBITS'(1);
            state_d     = (flushLeft_q == FLBITS'(1)) ? RUN : FLUSH;
        end else if (hazard) begin
            pcWrtEn = 1'b0;
            fdWrtEn = 1'b0;
            deNoop  = 1'b1;
            state_d = STALL;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (hazard && !squash && !(&stallCnt_q)) stallCnt_d = stallCnt_q + CNTBITS'(1);
        if (squash && !(&flushCnt_q))            flushCnt_d = flushCnt_q + CNTBITS'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            flushLeft_q <= '0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flushLeft_q <= flushLeft_d;
            stallCnt_q  <= stallCnt_d;
            flushCnt_q  <= flushCnt_d;
        end
    end

    assign stallCnt = stallCnt_q;
    assign flushCnt = flushCnt_q;
    assign dbgState = state_q;

endmodule

// File: tb/tb_de_hazard_ctrl.sv
// Bench for de_hazard_ctrl: three instances (FLUSH_CYCLES=1, FLUSH_CYCLES=3,
// CNTBITS=2) share one stimulus stream and are checked against a cycle model.
module tb_de_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       valid_D;
  logic [3:0] src1Index_D, src2Index_D, destIndex_D;
  logic       useSrc1_D, useSrc2_D, regWrtEn_D, mispredict_E;

  logic        pc_a, fdw_a, fdn_a, dew_a, den_a;
  logic        pc_b, fdw_b, fdn_b, dew_b, den_b;
  logic        pc_c, fdw_c, fdn_c, dew_c, den_c;
  logic [15:0] sc_a, fc_a, sc_b, fc_b;
  logic [1:0]  sc_c, fc_c;
  logic [1:0]  st_a, st_b, st_c;

  de_hazard_ctrl #(.REGBITS(4), .FLUSH_CYCLES(1), .CNTBITS(16)) dut_a (
    .clk(clk), .reset(reset), .valid_D(valid_D),
    .src1Index_D(src1Index_D), .src2Index_D(src2Index_D),
    .useSrc1_D(useSrc1_D), .useSrc2_D(useSrc2_D),
    .destIndex_D(destIndex_D), .regWrtEn_D(regWrtEn_D), .mispredict_E(mispredict_E),
    .pcWrtEn(pc_a), .fdWrtEn(fdw_a), .fdNoop(fdn_a), .deWrtEn(dew_a), .deNoop(den_a),
    .stallCnt(sc_a), .flushCnt(fc_a), .dbgState(st_a)
  );

  de_hazard_ctrl #(.REGBITS(4), .FLUSH_CYCLES(3), .CNTBITS(16)) dut_b (
    .clk(clk), .reset(reset), .valid_D(valid_D),
    .src1Index_D(src1Index_D), .src2Index_D(src2Index_D),
    .useSrc1_D(useSrc1_D), .useSrc2_D(useSrc2_D),
    .destIndex_D(destIndex_D), .regWrtEn_D(regWrtEn_D), .mispredict_E(mispredict_E),
    .pcWrtEn(pc_b), .fdWrtEn(fdw_b), .fdNoop(fdn_b), .deWrtEn(dew_b), .deNoop(den_b),
    .stallCnt(sc_b), .flushCnt(fc_b), .dbgState(st_b)
  );

  de_hazard_ctrl #(.REGBITS(4), .FLUSH_CYCLES(1), .CNTBITS(2)) dut_c (
    .clk(clk), .reset(reset), .valid_D(valid_D),
    .src1Index_D(src1Index_D), .src2Index_D(src2Index_D),
    .useSrc1_D(useSrc1_D), .useSrc2_D(useSrc2_D),
    .destIndex_D(destIndex_D), .regWrtEn_D(regWrtEn_D), .mispredict_E(mispredict_E),
    .pcWrtEn(pc_c), .fdWrtEn(fdw_c), .fdNoop(fdn_c), .deWrtEn(dew_c), .deNoop(den_c),
    .stallCnt(sc_c), .flushCnt(fc_c), .dbgState(st_c)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle model, one copy per instance. pend[0] is the write issued last cycle.
  int         flush_n [3] = '{1, 3, 1};
  int         cmax    [3] = '{65535, 65535, 3};
  bit         pend_v  [3][3];
  logic [3:0] pend_d  [3][3];
  int         fl_rem  [3];
  bit         was_stall [3];
  int         scnt    [3];
  int         fcnt    [3];

  // Scoreboard entry: {state[38:37], pc,fdW,fdN,deW,deN [36:32], stall[31:16], flush[15:0]}
  logic [38:0] exp_q[$];

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        pend_v[i][j] = 1'b0;
        pend_d[i][j] = '0;
      end
      fl_rem[i] = 0; was_stall[i] = 1'b0; scnt[i] = 0; fcnt[i] = 0;
    end
  endtask

  function automatic bit pending(int i, logic [3:0] r);
    for (int j = 0; j < 3; j++) if (pend_v[i][j] && pend_d[i][j] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit rst, input bit v, input logic [3:0] s1, input logic [3:0] s2,
                      input bit u1, input bit u2, input logic [3:0] d, input bit w, input bit m);
    logic [38:0] got [3];
    logic [38:0] e;
    bit          sq [3];
    bit          hz [3];
    logic [4:0]  outs;
    logic [1:0]  st;
    @(negedge clk);
    reset = rst; valid_D = v; src1Index_D = s1; src2Index_D = s2;
    useSrc1_D = u1; useSrc2_D = u2; destIndex_D = d; regWrtEn_D = w; mispredict_E = m;
    for (int i = 0; i < 3; i++) begin
      sq[i] = m || (fl_rem[i] > 0);
      hz[i] = v && ((u1 && pending(i, s1)) || (u2 && pending(i, s2)));
      st = (fl_rem[i] > 0) ? 2'd2 : (was_stall[i] ? 2'd1 : 2'd0);
      if (rst)        outs = 5'b01111;
      else if (sq[i]) outs = 5'b11111;
      else if (hz[i]) outs = 5'b00011;
      else            outs = {4'b1101, ~v};
      exp_q.push_back({st, outs, 16'(scnt[i]), 16'(fcnt[i])});
    end
    #4;
    got[0] = {st_a, pc_a, fdw_a, fdn_a, dew_a, den_a, sc_a, fc_a};
    got[1] = {st_b, pc_b, fdw_b, fdn_b, dew_b, den_b, sc_b, fc_b};
    got[2] = {st_c, pc_c, fdw_c, fdn_c, dew_c, den_c, 14'd0, sc_c, 14'd0, fc_c};
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      check_eq($sformatf("state%0d", i), 64'(got[i][38:37]), 64'(e[38:37]));
      check_eq($sformatf("ctl%0d", i),   64'(got[i][36:32]), 64'(e[36:32]));
      check_eq($sformatf("stallcnt%0d", i), 64'(got[i][31:16]), 64'(e[31:16]));
      check_eq($sformatf("flushcnt%0d", i), 64'(got[i][15:0]),  64'(e[15:0]));
    end
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int j = 0; j < 3; j++) pend_v[i][j] = 1'b0;
        fl_rem[i] = 0; was_stall[i] = 1'b0; scnt[i] = 0; fcnt[i] = 0;
      end else begin
        pend_v[i][2] = pend_v[i][1]; pend_d[i][2] = pend_d[i][1];
        pend_v[i][1] = pend_v[i][0]; pend_d[i][1] = pend_d[i][0];
        pend_v[i][0] = v && !hz[i] && !sq[i] && w;
        pend_d[i][0] = d;
        if (m)                fl_rem[i] = flush_n[i] - 1;
        else if (fl_rem[i] > 0) fl_rem[i] = fl_rem[i] - 1;
        was_stall[i] = hz[i] && !sq[i];
        if (hz[i] && !sq[i] && scnt[i] < cmax[i]) scnt[i]++;
        if (sq[i] && fcnt[i] < cmax[i]) fcnt[i]++;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; valid_D = 1'b0; src1Index_D = '0; src2Index_D = '0; destIndex_D = '0;
    useSrc1_D = 1'b0; useSrc2_D = 1'b0; regWrtEn_D = 1'b0; mispredict_E = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);

    // reset outputs, then RAW on E: three stalls, fourth cycle issues
    do_reset();
    step(0, 1, 0, 0, 0, 0, 5, 1, 0);
    repeat (4) step(0, 1, 5, 0, 1, 0, 6, 1, 0);
    idle();
    check_eq("raw_stallcnt", 64'(sc_a), 64'd3);

    // no false hazards
    do_reset();
    step(0, 1, 0, 0, 0, 0, 5, 1, 0);
    step(0, 1, 5, 5, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 7, 0, 0);
    step(0, 1, 7, 7, 1, 1, 2, 0, 0);
    step(0, 0, 7, 7, 1, 1, 0, 0, 0);
    check_eq("nofalse_stallcnt", 64'(sc_a), 64'd0);

    // single mispredict pulse
    do_reset();
    step(0, 1, 1, 2, 1, 1, 3, 1, 1);
    repeat (4) step(0, 1, 1, 2, 1, 1, 4, 0, 0);
    check_eq("misp_flushcnt_a", 64'(fc_a), 64'd1);
    check_eq("misp_flushcnt_b", 64'(fc_b), 64'd3);

    // mispredict while stalled: stalled dest 10 must never become pending
    do_reset();
    step(0, 1, 0, 0, 0, 0, 9, 1, 0);
    step(0, 1, 9, 0, 1, 0, 10, 1, 0);
    step(0, 1, 9, 0, 1, 0, 10, 1, 1);
    repeat (4) step(0, 1, 10, 10, 1, 1, 11, 0, 0);
    check_eq("stall_misp_stallcnt_b", 64'(sc_b), 64'd1);

    // reset during the second flush cycle
    do_reset();
    step(0, 1, 0, 0, 0, 0, 4, 1, 1);
    step(1, 1, 0, 0, 0, 0, 4, 1, 0);
    step(0, 1, 4, 0, 1, 0, 0, 0, 0);
    check_eq("rst_flush_state_b", 64'(st_b), 64'd0);
    check_eq("rst_flush_cnt_b", 64'(fc_b), 64'd0);

    // counter saturation on the 2-bit instance
    do_reset();
    step(0, 1, 0, 0, 0, 0, 3, 1, 0);
    repeat (4) step(0, 1, 3, 0, 1, 0, 3, 1, 0);
    repeat (4) step(0, 1, 0, 3, 0, 1, 2, 0, 0);
    idle();
    check_eq("sat_stallcnt_c", 64'(sc_c), 64'd3);
    check_eq("sat_stallcnt_a", 64'(sc_a), 64'd6);

    // random traffic on a small register range to provoke frequent hazards
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0);
    end

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/de_hazard_ctrl.md
Name: de_hazard_ctrl

Overview:
- Producer-side controller for the decode/execute pipeline buffer.
- Generates the write-enable and noop (bubble) controls that the F/D and D/E buffers consume.
- Keeps a 3-slot scoreboard of in-flight register writes (E, M, W stages). Stalls decode on RAW hazards; no forwarding exists.
- Squashes F and D on a branch mispredict resolved in E, and counts stall/flush cycles for performance debug.

Parameters:
- REGBITS, 4, width of register index.
- FLUSH_CYCLES, 1, cycles of squash after a mispredict (min 1).
- CNTBITS, 16, width of saturating performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- valid_D  in  1  decode stage holds a real instruction.
- src1Index_D  in  REGBITS  first source register.
- src2Index_D  in  REGBITS  second source register.
- useSrc1_D  in  1  instruction reads src1.
- useSrc2_D  in  1  instruction reads src2.
- destIndex_D  in  REGBITS  destination register.
- regWrtEn_D  in  1  instruction writes the register file.
- mispredict_E  in  1  branch in E resolved against prediction; PC redirect this cycle.
- pcWrtEn  out  1  PC register load enable.
- fdWrtEn  out  1  F/D buffer write enable.
- fdNoop  out  1  F/D buffer loads a bubble.
- deWrtEn  out  1  D/E buffer write enable.
- deNoop  out  1  D/E buffer loads a bubble (drives noop_D).
- stallCnt  out  CNTBITS  saturating count of STALL cycles.
- flushCnt  out  CNTBITS  saturating count of FLUSH cycles.

Behaviour:
- Scoreboard: slots sbE, sbM, sbW, each holding {valid, dest}.
  - Per cycle: sbW<=sbM; sbM<=sbE; sbE<={issue & regWrtEn_D, destIndex_D}.
  - issue = valid_D & ~hazard & ~squash.
  - Register file writes at the end of W, so all three slots are checked.
- hazard = valid_D & ((useSrc1_D & match(src1Index_D)) | (useSrc2_D & match(src2Index_D))).
  - match(x) = any valid slot with dest==x. Register 0 is not special.
- squash = mispredict_E | (state==FLUSH).
- FSM states: RUN, STALL, FLUSH. All outputs are combinational from state and inputs.
- Priority: mispredict_E > FLUSH > hazard > normal.
- Squash (mispredict_E, or state FLUSH):
  - pcWrtEn=1, fdWrtEn=1, fdNoop=1, deWrtEn=1, deNoop=1.
  - On mispredict_E: if FLUSH_CYCLES>1, go to FLUSH with flushLeft=FLUSH_CYCLES-1; else go to RUN.
  - In FLUSH: decrement flushLeft; go to RUN when it reaches 1.
  - mispredict_E while in FLUSH reloads flushLeft.
- Hazard, no squash (state STALL):
  - pcWrtEn=0, fdWrtEn=0, fdNoop=0, deWrtEn=1, deNoop=1.
  - Stay in STALL while hazard holds; return to RUN when hazard clears.
  - Maximum stall is 3 cycles, since the bubble drains the scoreboard.
- Normal: pcWrtEn=1, fdWrtEn=1, fdNoop=0, deWrtEn=1, deNoop=~valid_D.
- Mispredict during STALL: squash wins that cycle and the stalled D instruction is discarded (it never enters sbE).
- Counters:
  - stallCnt increments on cycles with hazard & ~squash.
  - flushCnt increments on squash cycles.
  - Both saturate at all-ones.
- Reset (synchronous, takes effect at the next edge; also applies mid-flush or mid-stall):
  - Scoreboard invalid, state RUN, flushLeft=0, counters=0.
  - While reset=1, outputs are forced to pcWrtEn=0, fdWrtEn=1, fdNoop=1, deWrtEn=1, deNoop=1, so both buffers fill with bubbles.

Decomposition:
- Shared pipeline package holds:
  - REGBITS default.
  - State encoding localparams (RUN=2'd0, STALL=2'd1, FLUSH=2'd2).
  - Scoreboard slot struct/width constant.
- One sub-module: hazard_scoreboard. It holds the 3-slot shift register and the match logic, with inputs issue/dest and outputs hit1/hit2.
- The FSM and counters stay in the top module.

Test Plan:
- RAW on E: cycle0 issue dest=5 regWrtEn=1; cycle1 D reads src1=5, useSrc1=1.
  - Required: deNoop=1, fdWrtEn=0, pcWrtEn=0 for 3 cycles (slot in E, M, W); 4th cycle issues normally.
  - stallCnt=3.
- No false hazard:
  - useSrc1=0 with src1=5 pending -> no stall.
  - Pending write with regWrtEn=0 -> no stall.
  - valid_D=0 -> deNoop=1, pcWrtEn=1.
- Mispredict, FLUSH_CYCLES=1: mispredict_E pulse at cycle t -> at t: fdNoop=deNoop=1, pcWrtEn=1; at t+1: normal; flushCnt=1.
- Mispredict during stall, FLUSH_CYCLES=3:
  - Hazard active, mispredict_E at t -> squash for t..t+2, stallCnt frozen.
  - The stalled instruction's dest never appears in the scoreboard (a subsequent read of it does not stall).
- Reset mid-FLUSH: reset at flush cycle 2 -> next cycle state RUN, counters 0, scoreboard empty; during reset fdNoop=deNoop=1 and pcWrtEn=0.
- Counter saturation: CNTBITS=2, force 5 stall cycles -> stallCnt holds 3.
